sdram_arbiter: RTL

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_pkg.sv | 22 ++
 rtl/sdram_ref_timer.sv | 52 +++++
 rtl/sdram_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, arbiter states, refresh defaults.
package sdram_pkg;

   localparam logic [3:0] CMD_NOP         = 4'b0111;
   localparam logic [3:0] CMD_PRECHARGE   = 4'b0010;
   localparam logic [3:0] CMD_AUTOREFRESH = 4'b0001;

   localparam logic [1:0]  BA_IDLE   = 2'b11;
   localparam logic [11:0] ADDR_IDLE = 12'hfff;

   localparam int unsigned REF_INTERVAL_DEF = 1500;

   typedef enum logic [2:0] {
      StInit  = 3'd0,
      StArbit = 3'd1,
      StAref  = 3'd2,
      StSref  = 3'd3,
      StWrite = 3'd4,
      StRead  = 3'd5
   } arb_state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer with pending request and sticky overrun flag.
module sdram_ref_timer
   import sdram_pkg::*;
#(
   parameter int unsigned REF_INTERVAL = REF_INTERVAL_DEF,
   parameter int unsigned CNT_W        = 11
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic count_en,
   input  logic aref_start,
   input  logic sr_exit,
   output logic aref_pending,
   output logic ref_overrun
);

   logic [CNT_W-1:0] cnt_q;
   logic             pending_q;
   logic             overrun_q;
   logic             wrap;

   assign wrap = count_en && (cnt_q == CNT_W'(REF_INTERVAL - 1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_q     <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else if (sr_exit) begin
         // Self-refresh exit already refreshed the device, so restart the interval.
         cnt_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         if (count_en) begin
            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
         end
         // A wrap coinciding with AREF entry re-arms pending for the next interval.
         if (wrap) begin
            pending_q <= 1'b1;
            if (pending_q && !aref_start) begin
               overrun_q <= 1'b1;
            end
         end else if (aref_start) begin
            pending_q <= 1'b0;
         end
      end
   end

   assign aref_pending = pending_q;
   assign ref_overrun  = overrun_q;

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: grants one sub-module at a time and muxes its bus to the device.
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int unsigned REF_INTERVAL = REF_INTERVAL_DEF,
   parameter int unsigned CNT_W        = 11
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        init_end,
   input  logic [3:0]  init_cmd,
   input  logic [1:0]  init_ba,
   input  logic [11:0] init_addr,
   input  logic        aref_done,
   input  logic [3:0]  aref_cmd,
   input  logic [1:0]  aref_ba,
   input  logic [11:0] aref_addr,
   input  logic        sr_req,
   input  logic        sr_done,
   input  logic        sr_cke,
   input  logic [3:0]  sr_cmd,
   input  logic [1:0]  sr_ba,
   input  logic [11:0] sr_addr,
   input  logic        wr_req,
   input  logic        wr_done,
   input  logic [3:0]  wr_cmd,
   input  logic [1:0]  wr_ba,
   input  logic [11:0] wr_addr,
   input  logic        rd_req,
   input  logic        rd_done,
   input  logic [3:0]  rd_cmd,
   input  logic [1:0]  rd_ba,
   input  logic [11:0] rd_addr,
   output logic        aref_en,
   output logic        sr_en,
   output logic        wr_en,
   output logic        rd_en,
   output logic        sdram_cke,
   output logic [3:0]  sdram_cmd,
   output logic [1:0]  sdram_ba,
   output logic [11:0] sdram_addr,
   output logic        ref_overrun
);

   arb_state_e state_q, state_d;
   logic aref_en_q, aref_en_d;
   logic sr_en_q, sr_en_d;
   logic wr_en_q, wr_en_d;
   logic rd_en_q, rd_en_d;
   logic last_wr_q, last_wr_d;
   logic aref_pending;

   sdram_ref_timer #(
      .REF_INTERVAL (REF_INTERVAL),
      .CNT_W        (CNT_W)
   ) u_ref_timer (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .count_en     (init_end && (state_q != StSref)),
      .aref_start   ((state_q == StArbit) && aref_pending),
      .sr_exit      ((state_q == StSref) && sr_done),
      .aref_pending (aref_pending),
      .ref_overrun  (ref_overrun)
   );

   always_comb begin
      state_d   = state_q;
      aref_en_d = aref_en_q;
      sr_en_d   = sr_en_q;
      wr_en_d   = wr_en_q;
      rd_en_d   = rd_en_q;
      last_wr_d = last_wr_q;
      case (state_q)
         StInit: if (init_end) state_d = StArbit;
         StArbit: begin
            if (aref_pending) begin
               state_d   = StAref;
               aref_en_d = 1'b1;
            end else if (sr_req) begin
               state_d = StSref;
               sr_en_d = 1'b1;
            end else if (wr_req && !(rd_req && last_wr_q)) begin
               // On a tie the side not served last time wins.
               state_d   = StWrite;
               wr_en_d   = 1'b1;
               last_wr_d = 1'b1;
            end else if (rd_req) begin
               state_d   = StRead;
               rd_en_d   = 1'b1;
               last_wr_d = 1'b0;
            end
         end
         StAref: if (aref_done) begin
            state_d   = StArbit;
            aref_en_d = 1'b0;
         end
         StSref: begin
            sr_en_d = sr_req;
            if (sr_done) begin
               state_d = StArbit;
               sr_en_d = 1'b0;
            end
         end
         StWrite: if (wr_done) begin
            state_d = StArbit;
            wr_en_d = 1'b0;
         end
         StRead: if (rd_done) begin
            state_d = StArbit;
            rd_en_d = 1'b0;
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= StInit;
         aref_en_q <= 1'b0;
         sr_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         last_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         aref_en_q <= aref_en_d;
         sr_en_q   <= sr_en_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         last_wr_q <= last_wr_d;
      end
   end

   assign aref_en = aref_en_q;
   assign sr_en   = sr_en_q;
   assign wr_en   = wr_en_q;
   assign rd_en   = rd_en_q;

   // Reset forces the idle bus even though the state reads as INIT.
   always_comb begin
      sdram_cke  = 1'b1;
      sdram_cmd  = CMD_NOP;
      sdram_ba   = BA_IDLE;
      sdram_addr = ADDR_IDLE;
      if (sys_rst_n) begin
         case (state_q)
            StInit: begin
               sdram_cmd  = init_cmd;
               sdram_ba   = init_ba;
               sdram_addr = init_addr;
            end
            StAref: begin
               sdram_cmd  = aref_cmd;
               sdram_ba   = aref_ba;
               sdram_addr = aref_addr;
            end
            StSref: begin
               sdram_cke  = sr_cke;
               sdram_cmd  = sr_cmd;
               sdram_ba   = sr_ba;
               sdram_addr = sr_addr;
            end
            StWrite: begin
               sdram_cmd  = wr_cmd;
               sdram_ba   = wr_ba;
               sdram_addr = wr_addr;
            end
            StRead: begin
               sdram_cmd  = rd_cmd;
               sdram_ba   = rd_ba;
               sdram_addr = rd_addr;
            end
            default: ;
         endcase
      end
   end

endmodule
